// File: rtl/sram_wport_arbiter_pkg.sv
// Shared constants and types for the SRAM write-port controller: lane count,
// requester indices and the layout of the pending pixel word.
package sram_wport_arbiter_pkg;

  localparam int PKG_WWORD = 32;
  localparam int PKG_WADDR = 5;
  localparam int PKG_DEPTH = 24;
  localparam int PKG_WP    = 8;

  function automatic int calc_nb(input int wword, input int wp);
    return wword / wp;
  endfunction

  localparam int PKG_NB = calc_nb(PKG_WWORD, PKG_WP);

  localparam logic R0_PIXEL = 1'b0;
  localparam logic R1_CNN   = 1'b1;

  typedef struct packed {
    logic [PKG_WWORD-1:0] data;
    logic [PKG_NB-1:0]    mask;
    logic [PKG_WADDR-1:0] addr;
    logic                 last;
  } pend_word_t;

  localparam int PEND_W = $bits(pend_word_t);

endpackage

// File: rtl/sram_wport_rr2.sv
// Two-way round-robin arbiter; the registered last grant decides ties and
// resets to the CNN side so the pixel requester wins the first tie.
module sram_wport_rr2
  import sram_wport_arbiter_pkg::*;
(
  input  logic       clk,
  input  logic       rstn,
  input  logic [1:0] i_req,
  output logic [1:0] o_gnt
);

  logic r_last;

  // Grant decode: a lone requester wins, a tie goes to the one not served last.
  always_comb begin
    o_gnt = 2'b00;
    case (i_req)
      2'b01:   o_gnt = 2'b01;
      2'b10:   o_gnt = 2'b10;
      2'b11:   o_gnt = (r_last == R1_CNN) ? 2'b01 : 2'b10;
      default: o_gnt = 2'b00;
    endcase
  end

  // Remember which requester was served most recently.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_last <= R1_CNN;
    end else if (o_gnt[R0_PIXEL]) begin
      r_last <= R0_PIXEL;
    end else if (o_gnt[R1_CNN]) begin
      r_last <= R1_CNN;
    end else begin
      r_last <= r_last;
    end
  end

endmodule

// File: rtl/sram_wport_arbiter.sv
// SRAM write-port controller: packs pixel bytes into masked words and shares
// the single write port round-robin with the CNN writer (pending word uses package widths).
module sram_wport_arbiter
  import sram_wport_arbiter_pkg::*;
#(
  parameter  int WWORD = PKG_WWORD,
  parameter  int WADDR = PKG_WADDR,
  parameter  int DEPTH = PKG_DEPTH,
  parameter  int WP    = PKG_WP,
  localparam int NB    = WWORD / WP
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             px_sof,
  input  logic             px_valid,
  output logic             px_ready,
  input  logic [WP-1:0]    px_data,
  input  logic             px_last,
  output logic             px_done,
  input  logic             wr_valid,
  output logic             wr_ready,
  input  logic [WADDR-1:0] wr_addr,
  input  logic [WWORD-1:0] wr_data,
  input  logic [NB-1:0]    wr_be,
  output logic             cenb,
  output logic [NB-1:0]    wenb,
  output logic [WADDR-1:0] ab,
  output logic [WWORD-1:0] db
);

  localparam int BCW = (NB > 1) ? $clog2(NB) : 1;

  logic [BCW-1:0]   r_bcnt;
  logic [NB-1:0]    r_mask;
  logic [WWORD-1:0] r_data;
  logic [WADDR-1:0] r_px_addr;
  pend_word_t       r_pend;
  logic             r_pend_valid;

  logic [BCW-1:0]   w_bcnt_base;
  logic [NB-1:0]    w_mask_base;
  logic [WWORD-1:0] w_data_base;
  logic [WADDR-1:0] w_addr_base;
  logic [NB-1:0]    w_mask_new;
  logic [WWORD-1:0] w_data_new;
  logic [WADDR-1:0] w_addr_next;
  logic             w_complete_req;
  logic             w_px_acc;
  logic             w_complete;
  logic [1:0]       w_gnt;

  // Start of frame overrides the partial word before the incoming byte is merged.
  always_comb begin
    w_bcnt_base = px_sof ? {BCW{1'b0}}   : r_bcnt;
    w_mask_base = px_sof ? {NB{1'b0}}    : r_mask;
    w_data_base = px_sof ? {WWORD{1'b0}} : r_data;
    w_addr_base = px_sof ? {WADDR{1'b0}} : r_px_addr;
    w_data_new  = w_data_base;
    w_data_new[w_bcnt_base*WP +: WP] = px_data;
    w_mask_new  = w_mask_base;
    w_mask_new[w_bcnt_base] = 1'b1;
    w_complete_req = px_valid & ((w_bcnt_base == BCW'(NB-1)) | px_last);
    w_addr_next = (w_addr_base == WADDR'(DEPTH-1)) ? {WADDR{1'b0}} : (w_addr_base + WADDR'(1));
  end

  // Stall only when a finished word would overwrite an unissued pending word.
  assign px_ready   = ~(r_pend_valid & w_complete_req & ~w_gnt[R0_PIXEL]);
  assign w_px_acc   = px_valid & px_ready;
  assign w_complete = w_complete_req & px_ready;
  assign wr_ready   = w_gnt[R1_CNN];

  sram_wport_rr2 u_rr2 (
    .clk   (clk),
    .rstn  (rstn),
    .i_req ({wr_valid, r_pend_valid}),
    .o_gnt (w_gnt)
  );

  // Byte packer: lane counter, partial word, mask and wrapping pixel address.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_bcnt    <= {BCW{1'b0}};
      r_mask    <= {NB{1'b0}};
      r_data    <= {WWORD{1'b0}};
      r_px_addr <= {WADDR{1'b0}};
    end else if (w_px_acc) begin
      if (w_complete_req) begin
        r_bcnt    <= {BCW{1'b0}};
        r_mask    <= {NB{1'b0}};
        r_data    <= {WWORD{1'b0}};
        r_px_addr <= w_addr_next;
      end else begin
        r_bcnt    <= w_bcnt_base + BCW'(1);
        r_mask    <= w_mask_new;
        r_data    <= w_data_new;
        r_px_addr <= w_addr_base;
      end
    end else if (px_sof) begin
      r_bcnt    <= {BCW{1'b0}};
      r_mask    <= {NB{1'b0}};
      r_data    <= {WWORD{1'b0}};
      r_px_addr <= {WADDR{1'b0}};
    end else begin
      r_bcnt    <= r_bcnt;
      r_mask    <= r_mask;
      r_data    <= r_data;
      r_px_addr <= r_px_addr;
    end
  end

  // Single-entry pending word; a new completion may refill it in its grant cycle.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_pend_valid <= 1'b0;
      r_pend       <= '0;
    end else if (w_complete) begin
      r_pend_valid <= 1'b1;
      r_pend       <= '{data: w_data_new, mask: w_mask_new, addr: w_addr_base, last: px_last};
    end else if (w_gnt[R0_PIXEL]) begin
      r_pend_valid <= 1'b0;
      r_pend       <= r_pend;
    end else begin
      r_pend_valid <= r_pend_valid;
      r_pend       <= r_pend;
    end
  end

  // SRAM write-port register: one active-low strobe per granted write.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cenb    <= 1'b1;
      wenb    <= {NB{1'b1}};
      ab      <= {WADDR{1'b0}};
      db      <= {WWORD{1'b0}};
      px_done <= 1'b0;
    end else if (w_gnt[R0_PIXEL]) begin
      cenb    <= 1'b0;
      wenb    <= ~r_pend.mask;
      ab      <= r_pend.addr;
      db      <= r_pend.data;
      px_done <= r_pend.last;
    end else if (w_gnt[R1_CNN]) begin
      cenb    <= 1'b0;
      wenb    <= ~wr_be;
      ab      <= wr_addr;
      db      <= wr_data;
      px_done <= 1'b0;
    end else begin
      cenb    <= 1'b1;
      wenb    <= {NB{1'b1}};
      ab      <= ab;
      db      <= db;
      px_done <= 1'b0;
    end
  end

endmodule

// File: tb/tb_sram_wport_arbiter.sv
// Directed bench for sram_wport_arbiter: every SRAM write strobe is logged and
// each scenario task checks the log against hand-computed words.
module tb_sram_wport_arbiter;

  logic        clk = 1'b0;
  logic        rstn;
  logic        px_sof, px_valid, px_last, px_ready, px_done;
  logic [7:0]  px_data;
  logic        wr_valid, wr_ready;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic [3:0]  wr_be;
  logic        cenb;
  logic [3:0]  wenb;
  logic [4:0]  ab;
  logic [31:0] db;

  int total = 0;
  int bad = 0;
  int stall_cnt = 0;

  logic [4:0]  q_ab[$];
  logic [31:0] q_db[$];
  logic [3:0]  q_wenb[$];
  logic        q_done[$];

  sram_wport_arbiter dut (
    .clk(clk), .rstn(rstn),
    .px_sof(px_sof), .px_valid(px_valid), .px_ready(px_ready), .px_data(px_data),
    .px_last(px_last), .px_done(px_done),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be),
    .cenb(cenb), .wenb(wenb), .ab(ab), .db(db)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rstn === 1'b1 && cenb === 1'b0) begin
      q_ab.push_back(ab);
      q_db.push_back(db);
      q_wenb.push_back(wenb);
      q_done.push_back(px_done);
    end
  end

  task automatic clear_log();
    q_ab.delete(); q_db.delete(); q_wenb.delete(); q_done.delete();
  endtask

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic idle_px();
    px_valid = 1'b0; px_last = 1'b0; px_sof = 1'b0;
  endtask

  task automatic push_px(input logic [7:0] d, input logic l, input logic s);
    logic rdy;
    int n;
    px_valid = 1'b1; px_data = d; px_last = l; px_sof = s;
    rdy = 1'b0; n = 0;
    while (!rdy && n < 40) begin
      #1;
      rdy = px_ready;
      if (!rdy) stall_cnt++;
      @(posedge clk); #1;
      px_sof = 1'b0;
      n++;
    end
    total++;
    if (!rdy) begin bad++; $display("FAIL push_timeout got=stalled want=accepted"); end
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    idle_px(); px_data = 8'h00;
    wr_valid = 1'b0; wr_addr = 5'd0; wr_data = 32'h0; wr_be = 4'h0;
    #12;
    total++; if (cenb !== 1'b1) begin bad++; $display("FAIL reset_cenb got=%b want=1", cenb); end
    total++; if (wenb !== 4'hF) begin bad++; $display("FAIL reset_wenb got=%h want=f", wenb); end
    total++; if (ab !== 5'd0) begin bad++; $display("FAIL reset_ab got=%0d want=0", ab); end
    total++; if (db !== 32'h0) begin bad++; $display("FAIL reset_db got=%h want=0", db); end
    total++; if (px_done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", px_done); end
    total++; if (px_ready !== 1'b1) begin bad++; $display("FAIL reset_pxready got=%b want=1", px_ready); end
    total++; if (wr_ready !== 1'b0) begin bad++; $display("FAIL reset_wrready got=%b want=0", wr_ready); end
    @(posedge clk); #1;
    rstn = 1'b1;
    tick(2);
  endtask

  task automatic test_one_word();
    clear_log();
    push_px(8'h11, 1'b0, 1'b1);
    push_px(8'h22, 1'b0, 1'b0);
    push_px(8'h33, 1'b0, 1'b0);
    push_px(8'h44, 1'b0, 1'b0);
    idle_px();
    tick(5);
    total++;
    if (q_ab.size() != 1) begin
      bad++; $display("FAIL word_count got=%0d want=1", q_ab.size());
    end else begin
      total++; if (q_ab[0] !== 5'd0) begin bad++; $display("FAIL word_ab got=%0d want=0", q_ab[0]); end
      total++; if (q_db[0] !== 32'h44332211) begin bad++; $display("FAIL word_db got=%h want=44332211", q_db[0]); end
      total++; if (q_wenb[0] !== 4'b0000) begin bad++; $display("FAIL word_wenb got=%b want=0000", q_wenb[0]); end
      total++; if (q_done[0] !== 1'b0) begin bad++; $display("FAIL word_done got=%b want=0", q_done[0]); end
    end
  endtask

  task automatic test_last_flush();
    clear_log();
    push_px(8'h01, 1'b0, 1'b1);
    for (int i = 2; i <= 5; i++) push_px(8'(i), 1'b0, 1'b0);
    push_px(8'h06, 1'b1, 1'b0);
    idle_px();
    tick(5);
    total++;
    if (q_ab.size() != 2) begin
      bad++; $display("FAIL flush_count got=%0d want=2", q_ab.size());
    end else begin
      total++; if (q_ab[0] !== 5'd0 || q_db[0] !== 32'h04030201 || q_wenb[0] !== 4'b0000 || q_done[0] !== 1'b0) begin
        bad++; $display("FAIL flush_w0 got=%0d/%h/%b/%b want=0/04030201/0000/0", q_ab[0], q_db[0], q_wenb[0], q_done[0]);
      end
      total++; if (q_ab[1] !== 5'd1 || q_db[1][15:0] !== 16'h0605 || q_wenb[1] !== 4'b1100) begin
        bad++; $display("FAIL flush_w1 got=%0d/%h/%b want=1/0605/1100", q_ab[1], q_db[1][15:0], q_wenb[1]);
      end
      total++; if (q_done[1] !== 1'b1) begin bad++; $display("FAIL flush_done got=%b want=1", q_done[1]); end
    end
  endtask

  task automatic test_wrap_stream();
    logic [31:0] exp_db;
    clear_log();
    stall_cnt = 0;
    push_px(8'h00, 1'b0, 1'b1);
    for (int i = 1; i < 100; i++) push_px(8'(i), 1'b0, 1'b0);
    idle_px();
    tick(6);
    total++; if (stall_cnt != 0) begin bad++; $display("FAIL wrap_stalls got=%0d want=0", stall_cnt); end
    total++;
    if (q_ab.size() != 25) begin
      bad++; $display("FAIL wrap_count got=%0d want=25", q_ab.size());
    end else begin
      for (int k = 0; k < 25; k++) begin
        exp_db = {8'(4*k+3), 8'(4*k+2), 8'(4*k+1), 8'(4*k)};
        total++;
        if (q_ab[k] !== 5'(k % 24) || q_db[k] !== exp_db || q_wenb[k] !== 4'b0000) begin
          bad++; $display("FAIL wrap_w%0d got=%0d/%h want=%0d/%h", k, q_ab[k], q_db[k], k % 24, exp_db);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    int acc;
    int n_cnn;
    int n_px;
    clear_log();
    stall_cnt = 0;
    acc = 0; n_cnn = 0; n_px = 0;
    wr_addr = 5'd7; wr_data = 32'hDEADBEEF; wr_be = 4'b0101;
    fork
      begin
        push_px(8'h80, 1'b0, 1'b1);
        for (int i = 1; i < 8; i++) push_px(8'(128 + i), 1'b0, 1'b0);
        idle_px();
      end
      begin
        for (int c = 0; c < 20; c++) begin
          wr_valid = 1'b1;
          #1;
          if (wr_ready === 1'b1) acc++;
          @(posedge clk); #1;
        end
        wr_valid = 1'b0;
      end
    join
    tick(5);
    for (int k = 0; k < q_ab.size(); k++) begin
      total++;
      if (q_ab[k] == 5'd7) begin
        n_cnn++;
        if (q_db[k] !== 32'hDEADBEEF || q_wenb[k] !== 4'b1010) begin
          bad++; $display("FAIL mix_cnn%0d got=%h/%b want=deadbeef/1010", k, q_db[k], q_wenb[k]);
        end
      end else begin
        if (q_ab[k] !== 5'(n_px) || q_db[k] !== ((n_px == 0) ? 32'h83828180 : 32'h87868584) || q_wenb[k] !== 4'b0000) begin
          bad++; $display("FAIL mix_px%0d got=%0d/%h/%b want=%0d/px/0000", n_px, q_ab[k], q_db[k], q_wenb[k], n_px);
        end
        n_px++;
      end
    end
    total++; if (n_px != 2) begin bad++; $display("FAIL mix_px_count got=%0d want=2", n_px); end
    total++; if (n_cnn != 18) begin bad++; $display("FAIL mix_cnn_count got=%0d want=18", n_cnn); end
    total++; if (acc != 18) begin bad++; $display("FAIL mix_wr_accepts got=%0d want=18", acc); end
    total++; if (stall_cnt != 0) begin bad++; $display("FAIL mix_px_stalls got=%0d want=0", stall_cnt); end
  endtask

  task automatic test_sof_mid_word();
    clear_log();
    push_px(8'hA1, 1'b0, 1'b1);
    push_px(8'hA2, 1'b0, 1'b0);
    push_px(8'hB1, 1'b0, 1'b1);
    push_px(8'hB2, 1'b0, 1'b0);
    push_px(8'hB3, 1'b0, 1'b0);
    push_px(8'hB4, 1'b0, 1'b0);
    idle_px();
    tick(5);
    total++;
    if (q_ab.size() != 1) begin
      bad++; $display("FAIL sof_count got=%0d want=1", q_ab.size());
    end else begin
      total++; if (q_ab[0] !== 5'd0 || q_db[0] !== 32'hB4B3B2B1 || q_wenb[0] !== 4'b0000) begin
        bad++; $display("FAIL sof_word got=%0d/%h/%b want=0/b4b3b2b1/0000", q_ab[0], q_db[0], q_wenb[0]);
      end
    end
  endtask

  task automatic test_reset_mid_op();
    clear_log();
    push_px(8'hC1, 1'b0, 1'b1);
    push_px(8'hC2, 1'b0, 1'b0);
    push_px(8'hC3, 1'b0, 1'b0);
    push_px(8'hC4, 1'b0, 1'b0);
    push_px(8'hC5, 1'b1, 1'b0);
    idle_px();
    total++; if (cenb !== 1'b0) begin bad++; $display("FAIL rst_pre_cenb got=%b want=0", cenb); end
    rstn = 1'b0;
    #1;
    total++; if (cenb !== 1'b1) begin bad++; $display("FAIL rst_async_cenb got=%b want=1", cenb); end
    total++; if (wenb !== 4'hF) begin bad++; $display("FAIL rst_async_wenb got=%h want=f", wenb); end
    tick(2);
    rstn = 1'b1;
    tick(6);
    total++; if (q_ab.size() != 0) begin bad++; $display("FAIL rst_lost_pending got=%0d want=0", q_ab.size()); end
    total++; if (ab !== 5'd0) begin bad++; $display("FAIL rst_ab got=%0d want=0", ab); end
  endtask

  initial begin
    test_reset();
    test_one_word();
    test_last_flush();
    test_wrap_stream();
    test_back_to_back();
    test_sof_mid_word();
    test_reset_mid_op();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
